wb_burst_master: RTL
====================

// Module: wb_burst_master
// PURPOSE
//  Parametrised Wishbone B3 burst master for the SDRAM controller environment.
//  Turns a command handshake into single or incrementing-burst bus cycles and supports wait-states.
//  Streams write data in and read data out, with an ack watchdog.
//  Sits between the test/app layer and the sdr_ctrl Wishbone slave port.
// PARAMETERS
//  dw       32   data width in bits; must be a multiple of 8
//  APP_AW   26   byte-address width
//  MAX_BL   8    maximum beats per burst, >=1
//  TIMEOUT  256  cycles without ack before abort; 0 disables the watchdog
//  BLW      $clog2(MAX_BL+1)  localparam, width of the length field
// PORTS
//  wb_clk_i   in   1         clock
//  wb_rst_i   in   1         synchronous reset, active-low
//  cmd_valid  in   1         command request
//  cmd_ready  out  1         command accepted when cmd_valid&&cmd_ready
//  cmd_we     in   1         1=write burst, 0=read burst
//  cmd_addr   in   APP_AW    start byte address
//  cmd_len    in   BLW       beat count
//  cmd_sel    in   dw/8      byte enables, applied to every beat
//  wr_valid   in   1         write beat available
//  wr_ready   out  1         write beat taken when wr_valid&&wr_ready
//  wr_data    in   dw        write beat data
//  rd_valid   out  1         read beat strobe (no backpressure)
//  rd_data    out  dw        read beat data
//  done       out  1         one-cycle pulse at burst end
//  err        out  1         one-cycle pulse with done when aborted by timeout
//  wb_cyc_o, wb_stb_o, wb_we_o  out  1        Wishbone control
//  wb_addr_o  out  APP_AW    bus address
//  wb_dat_o   out  dw        bus write data
//  wb_sel_o   out  dw/8      bus byte enables
//  wb_cti_o   out  3         cycle type identifier
//  wb_ack_i   in   1         slave acknowledge
//  wb_dat_i   in   dw        slave read data
// BEHAVIOUR
//  Reset (wb_rst_i==0 at a clock edge):
//   - all outputs 0 and the FSM goes to IDLE; cmd_ready becomes 1 after reset releases.
//   - reset mid-burst drops cyc/stb at that edge, discards remaining beats, gives no done.
//  FSM IDLE->BUS->FIN->IDLE.
//   - cmd_ready=1 only in IDLE.
//   - Acceptance at edge N: cyc=1 from N+1, addr=cmd_addr, beat counter loaded.
//  cmd_len handling:
//   - cmd_len>MAX_BL is clamped to MAX_BL.
//   - cmd_len==0 goes to FIN directly: done pulses at N+1, no bus activity.
//  wb_cti_o:
//   - single beat: 3'b000.
//   - burst: 3'b010 on every beat except the last, 3'b111 on the last.
//  Addressing: addr advances by dw/8 on each ack and wraps modulo 2**APP_AW.
//  Read burst: stb stays high from N+1 to the final ack.
//   - rd_valid/rd_data are registered, one cycle after each ack.
//  Write burst uses a one-beat holding register; stb = cyc && hold_valid.
//   - wr_ready = write burst && beats_loaded<len && (!hold_valid || wb_ack_i).
//   - Once raised, stb is never dropped before ack.
//   - Missing wr_data inserts master wait-states: stb low, cyc high, cti held.
//  Final ack: cyc/stb/cti clear at the next edge (FIN); done pulses in FIN.
//  Ack seen while stb==0 is ignored.
//  Watchdog counts cycles with stb&&!ack and clears on ack.
//   - At TIMEOUT: cyc/stb drop, then done=1 and err=1 in FIN.
//  wb_we_o and wb_sel_o are constant for the whole cycle.
// STRUCTURE
//  Shared package wb_pkg holds:
//   - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111
//   - typedef enum {IDLE,BUS,FIN} wbm_state_t
//  One sub-module, wb_ack_watchdog: TIMEOUT counter with inputs arm/ack and a tmo pulse output.
// TESTING
//  - Read, len=1, addr=0x100, ack after 2 waits
//    -> cti=000, one rd_valid, done 1 cycle after cyc drops.
//  - Read, len=4, addr=0x3FFFFFC, zero-wait acks
//    -> addrs 0x3FFFFFC,0,4,8; cti 010,010,010,111; 4 rd_valid beats.
//  - Write, len=8, wr_valid deasserted 3 cycles after beat 2
//    -> stb low/cyc high for those cycles, 8 acked beats, data in order.
//  - cmd_len=0, then cmd_len=15 with MAX_BL=8
//    -> first gives done only; second gives 8 beats, last cti=111.
//  - Slave never acks, TIMEOUT=16
//    -> cyc drops after 16 stb cycles; done and err pulse together.
//  - wb_rst_i=0 during beat 3 of a 6-beat write
//    -> cyc=stb=0 next edge, no done, next command starts cleanly.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst master: cycle type codes and FSM states.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    FIN  = 2'd2
  } wbm_state_t;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 master-side bus bundle.
// Handshake: a beat completes on a clock edge where wb_cyc_o && wb_stb_o && wb_ack_i;
// an ack while wb_stb_o is low means nothing, and stb is never withdrawn before its ack.
interface wb_burst_master_if #(
  parameter int dw     = 32,
  parameter int APP_AW = 26
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;
  logic [dw-1:0]     wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive strobe cycles without an acknowledge and pulses tmo on the
// TIMEOUT-th such cycle. TIMEOUT of 0 disables the watchdog entirely.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic ack,
  output logic tmo
);
  if (TIMEOUT == 0) begin : g_off
    assign tmo = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count un-acked strobe cycles; any ack or idle strobe restarts the count.
    always_comb begin
      cnt_d = cnt_q;
      if (!arm || ack)        cnt_d = '0;
      else if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign tmo = arm && !ack && (cnt_q == LAST);
  end
endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: turns one command into a single or incrementing burst,
// streams write beats through a one-entry holding register and returns read beats
// one cycle after their ack. A stuck slave is abandoned by the ack watchdog.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int MAX_BL  = 8,
  parameter int TIMEOUT = 256,
  localparam int BLW    = $clog2(MAX_BL + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [BLW-1:0]    cmd_len,
  input  logic [dw/8-1:0]   cmd_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [dw-1:0]     wr_data,
  output logic              rd_valid,
  output logic [dw-1:0]     rd_data,
  output logic              done,
  output logic              err,
  output wbm_state_t        dbg_state,
  wb_burst_master_if.master wb
);
  localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(dw / 8);
  localparam logic [BLW-1:0]    MAX_LEN   = BLW'(MAX_BL);

  wbm_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [dw/8-1:0]   sel_q, sel_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [BLW-1:0]    len_q, len_d;
  logic [BLW-1:0]    acked_q, acked_d;
  logic [BLW-1:0]    loaded_q, loaded_d;
  logic              hold_valid_q, hold_valid_d;
  logic [dw-1:0]     hold_data_q, hold_data_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [dw-1:0]     rd_data_q, rd_data_d;

  logic           in_bus, stb, ack_eff, last_beat, wr_take, tmo;
  logic [BLW-1:0] len_clamped;

  // Read bursts strobe continuously; write bursts strobe only while a beat is held.
  assign in_bus      = (state_q == BUS);
  assign stb         = in_bus && (!we_q || hold_valid_q);
  assign ack_eff     = stb && wb.wb_ack_i;
  assign last_beat   = (acked_q == (len_q - 1'b1));
  assign wr_ready    = in_bus && we_q && (loaded_q < len_q) && (!hold_valid_q || ack_eff);
  assign wr_take     = wr_ready && wr_valid;
  assign cmd_ready   = (state_q == IDLE) && wb_rst_i;
  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  wb_ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .arm   (stb),
    .ack   (wb.wb_ack_i),
    .tmo   (tmo)
  );

  // Next-state and datapath updates for command capture, beat streaming and completion.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    len_d        = len_q;
    acked_d      = acked_q;
    loaded_d     = loaded_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    err_d        = err_q;
    rd_valid_d   = ack_eff && !we_q;
    rd_data_d    = (ack_eff && !we_q) ? wb.wb_dat_i : rd_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          we_d         = cmd_we;
          sel_d        = cmd_sel;
          addr_d       = cmd_addr;
          len_d        = len_clamped;
          acked_d      = '0;
          loaded_d     = '0;
          hold_valid_d = 1'b0;
          err_d        = 1'b0;
          state_d      = (len_clamped == '0) ? FIN : BUS;
        end
      end
      BUS: begin
        if (wr_take) begin
          hold_data_d  = wr_data;
          hold_valid_d = 1'b1;
          loaded_d     = loaded_q + 1'b1;
        end else if (ack_eff) begin
          hold_valid_d = 1'b0;
        end
        if (ack_eff) begin
          addr_d  = addr_q + ADDR_STEP;
          acked_d = acked_q + 1'b1;
          if (last_beat) state_d = FIN;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      acked_q      <= '0;
      loaded_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      acked_q      <= acked_d;
      loaded_q     <= loaded_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign wb.wb_cyc_o  = in_bus;
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = in_bus && we_q;
  assign wb.wb_sel_o  = in_bus ? sel_q : '0;
  assign wb.wb_addr_o = in_bus ? addr_q : '0;
  assign wb.wb_dat_o  = (in_bus && we_q) ? hold_data_q : '0;
  assign wb.wb_cti_o  = (!in_bus || len_q == BLW'(1)) ? CTI_CLASSIC :
                        (last_beat ? CTI_EOB : CTI_INCR);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign done         = (state_q == FIN);
  assign err          = (state_q == FIN) && err_q;
  assign dbg_state    = state_q;
endmodule
